// File: rtl/tmr_scrub_monitor.sv
// TMR checker: registered bitwise majority vote, one-cycle scrub write-back,
// fault report over valid/ready and saturating per-lane fault counters.
module tmr_scrub_monitor #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] port_in_0,
   input  logic [WIDTH-1:0] port_in_1,
   input  logic [WIDTH-1:0] port_in_2,
   output logic [WIDTH-1:0] port_out,
   output logic             scrub_en,
   output logic [WIDTH-1:0] scrub_data,
   output logic             err_valid,
   input  logic             err_ready,
   output logic [1:0]       err_lane,
   output logic [WIDTH-1:0] err_mask,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_0,
   output logic [CNT_W-1:0] cnt_1,
   output logic [CNT_W-1:0] cnt_2,
   output logic             multi_fault
);

   typedef enum logic [1:0] {StIdle, StScrub, StReport} state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_port_out;
   logic             r_scrub_en;
   logic [WIDTH-1:0] r_scrub_data;
   logic             r_err_valid;
   logic [1:0]       r_err_lane;
   logic [WIDTH-1:0] r_err_mask;
   logic             r_multi_fault;
   logic [CNT_W-1:0] r_cnt [3];

   logic [WIDTH-1:0] w_vote;
   logic [WIDTH-1:0] w_mask;
   logic [2:0]       w_dis;
   logic             w_multi;
   logic             w_capture;
   logic [2:0]       w_inc;
   logic [1:0]       w_lane;

   always_comb begin
      w_vote    = (port_in_0 & port_in_1) | (port_in_1 & port_in_2) | (port_in_0 & port_in_2);
      w_dis[0]  = |(port_in_0 ^ w_vote);
      w_dis[1]  = |(port_in_1 ^ w_vote);
      w_dis[2]  = |(port_in_2 ^ w_vote);
      w_mask    = (port_in_0 ^ w_vote) | (port_in_1 ^ w_vote) | (port_in_2 ^ w_vote);
      w_multi   = (w_dis[0] & w_dis[1]) | (w_dis[1] & w_dis[2]) | (w_dis[0] & w_dis[2]);
      w_capture = (r_state == StIdle) && (|w_dis);
      w_inc     = w_capture ? w_dis : 3'b000;
      w_lane    = 2'd2;
      if (w_multi) begin
         w_lane = 2'd3;
      end else if (w_dis[0]) begin
         w_lane = 2'd0;
      end else if (w_dis[1]) begin
         w_lane = 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StIdle;
         r_port_out    <= '0;
         r_scrub_en    <= 1'b0;
         r_scrub_data  <= '0;
         r_err_valid   <= 1'b0;
         r_err_lane    <= 2'd0;
         r_err_mask    <= '0;
         r_multi_fault <= 1'b0;
      end else begin
         r_port_out <= w_vote;
         case (r_state)
            StIdle: begin
               if (w_capture) begin
                  r_err_lane   <= w_lane;
                  r_err_mask   <= w_mask;
                  r_scrub_data <= w_vote;
                  r_scrub_en   <= 1'b1;
                  r_state      <= StScrub;
                  if (w_multi) begin
                     r_multi_fault <= 1'b1;
                  end
               end
            end
            StScrub: begin
               r_scrub_en  <= 1'b0;
               r_err_valid <= 1'b1;
               r_state     <= StReport;
            end
            StReport: begin
               if (err_ready) begin
                  r_err_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_scrub_en  <= 1'b0;
               r_err_valid <= 1'b0;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   // A clear coinciding with an event yields 1: clear first, then count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            r_cnt[i] <= '0;
         end else if (cnt_clr) begin
            r_cnt[i] <= w_inc[i] ? CNT_W'(1) : '0;
         end else if (w_inc[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
         end
      end
   end

   assign port_out    = r_port_out;
   assign scrub_en    = r_scrub_en;
   assign scrub_data  = r_scrub_data;
   assign err_valid   = r_err_valid;
   assign err_lane    = r_err_lane;
   assign err_mask    = r_err_mask;
   assign multi_fault = r_multi_fault;
   assign cnt_0       = r_cnt[0];
   assign cnt_1       = r_cnt[1];
   assign cnt_2       = r_cnt[2];

endmodule

// File: tb/tb_tmr_scrub_monitor.sv
// Directed bench for tmr_scrub_monitor (WIDTH=4, CNT_W=2) with immediate-assertion checks.
module tb_tmr_scrub_monitor;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 2;

   logic          clk;
   logic          rst;
   logic [W-1:0]  in0, in1, in2;
   logic [W-1:0]  port_out;
   logic          scrub_en;
   logic [W-1:0]  scrub_data;
   logic          err_valid;
   logic          err_ready;
   logic [1:0]    err_lane;
   logic [W-1:0]  err_mask;
   logic          cnt_clr;
   logic [CW-1:0] cnt_0, cnt_1, cnt_2;
   logic          multi_fault;

   int n_tests = 0;
   int n_fail  = 0;

   tmr_scrub_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .port_in_0   (in0),
      .port_in_1   (in1),
      .port_in_2   (in2),
      .port_out    (port_out),
      .scrub_en    (scrub_en),
      .scrub_data  (scrub_data),
      .err_valid   (err_valid),
      .err_ready   (err_ready),
      .err_lane    (err_lane),
      .err_mask    (err_mask),
      .cnt_clr     (cnt_clr),
      .cnt_0       (cnt_0),
      .cnt_1       (cnt_1),
      .cnt_2       (cnt_2),
      .multi_fault (multi_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic lanes(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      in0 = a;
      in1 = b;
      in2 = c;
   endtask

   initial begin
      rst = 1'b1; err_ready = 1'b0; cnt_clr = 1'b0;
      lanes(4'b0000, 4'b0000, 4'b0000);
      tick();
      tick();
      check("rst_port_out", 32'(port_out), 32'h0);
      check("rst_scrub_en", 32'(scrub_en), 32'h0);
      check("rst_err_valid", 32'(err_valid), 32'h0);
      check("rst_err_lane", 32'(err_lane), 32'h0);
      check("rst_err_mask", 32'(err_mask), 32'h0);
      check("rst_cnt", {cnt_0, cnt_1, cnt_2}, 32'h0);
      check("rst_multi", 32'(multi_fault), 32'h0);

      // Clean votes.
      rst = 1'b0; err_ready = 1'b1;
      lanes(4'b0101, 4'b0101, 4'b0101);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("clean_port_out", 32'(port_out), 32'h5);
         check("clean_scrub_en", 32'(scrub_en), 32'h0);
         check("clean_err_valid", 32'(err_valid), 32'h0);
      end
      check("clean_cnt", {cnt_0, cnt_1, cnt_2}, 32'h0);

      // Single fault on lane 1.
      lanes(4'b0101, 4'b0111, 4'b0101);
      tick();
      check("l1_port_out", 32'(port_out), 32'h5);
      check("l1_scrub_en", 32'(scrub_en), 32'h1);
      check("l1_scrub_data", 32'(scrub_data), 32'h5);
      check("l1_valid_early", 32'(err_valid), 32'h0);
      check("l1_cnt_1", 32'(cnt_1), 32'h1);
      lanes(4'b0101, 4'b0101, 4'b0101);
      tick();
      check("l1_scrub_off", 32'(scrub_en), 32'h0);
      check("l1_err_valid", 32'(err_valid), 32'h1);
      check("l1_err_lane", 32'(err_lane), 32'h1);
      check("l1_err_mask", 32'(err_mask), 32'h2);
      tick();
      check("l1_handshake", 32'(err_valid), 32'h0);
      tick();
      check("l1_idle_valid", 32'(err_valid), 32'h0);
      check("l1_idle_scrub", 32'(scrub_en), 32'h0);

      // Multi-lane fault: lanes 0 and 2 on different bits.
      lanes(4'b0100, 4'b0101, 4'b1101);
      tick();
      check("m_scrub_en", 32'(scrub_en), 32'h1);
      check("m_scrub_data", 32'(scrub_data), 32'h5);
      check("m_cnt_0", 32'(cnt_0), 32'h1);
      check("m_cnt_1", 32'(cnt_1), 32'h1);
      check("m_cnt_2", 32'(cnt_2), 32'h1);
      check("m_multi", 32'(multi_fault), 32'h1);
      lanes(4'b0101, 4'b0101, 4'b0101);
      tick();
      check("m_err_valid", 32'(err_valid), 32'h1);
      check("m_err_lane", 32'(err_lane), 32'h3);
      check("m_err_mask", 32'(err_mask), 32'h9);
      tick();
      check("m_handshake", 32'(err_valid), 32'h0);
      tick();
      check("m_multi_sticky", 32'(multi_fault), 32'h1);

      // Back-pressure: lane-0 fault during a stalled report is not counted.
      err_ready = 1'b0;
      lanes(4'b0101, 4'b0001, 4'b0101);
      tick();
      check("bp_cnt_1", 32'(cnt_1), 32'h2);
      lanes(4'b0111, 4'b0101, 4'b0101);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_err_valid", 32'(err_valid), 32'h1);
         check("bp_err_lane", 32'(err_lane), 32'h1);
         check("bp_err_mask", 32'(err_mask), 32'h4);
         check("bp_cnt_0", 32'(cnt_0), 32'h1);
      end
      err_ready = 1'b1;
      tick();
      check("bp_handshake", 32'(err_valid), 32'h0);
      check("bp_no_capture", 32'(cnt_0), 32'h1);
      tick();
      check("bp_l0_scrub", 32'(scrub_en), 32'h1);
      check("bp_l0_cnt_0", 32'(cnt_0), 32'h2);
      lanes(4'b0101, 4'b0101, 4'b0101);
      tick();
      check("bp_l0_lane", 32'(err_lane), 32'h0);
      check("bp_l0_mask", 32'(err_mask), 32'h2);
      tick();
      check("bp_l0_done", 32'(err_valid), 32'h0);

      // Lane-2 faults: counter starts at 1 and saturates at 3.
      for (int k = 1; k <= 5; k++) begin
         lanes(4'b0101, 4'b0101, 4'b0100);
         tick();
         check("sat_cnt_2", 32'(cnt_2), (k + 1 > 3) ? 32'h3 : 32'(k + 1));
         lanes(4'b0101, 4'b0101, 4'b0101);
         tick();
         tick();
      end
      check("sat_cnt_0", 32'(cnt_0), 32'h2);
      lanes(4'b0101, 4'b0101, 4'b0100);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_inc_cnt_2", 32'(cnt_2), 32'h1);
      check("clr_cnt_0", 32'(cnt_0), 32'h0);
      check("clr_cnt_1", 32'(cnt_1), 32'h0);
      lanes(4'b0101, 4'b0101, 4'b0101);
      tick();
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_only_cnt_2", 32'(cnt_2), 32'h0);

      // Reset during REPORT.
      lanes(4'b0101, 4'b1101, 4'b0101);
      tick();
      check("rr_cnt_1", 32'(cnt_1), 32'h1);
      lanes(4'b0101, 4'b0101, 4'b0101);
      err_ready = 1'b0;
      tick();
      check("rr_valid", 32'(err_valid), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr_err_valid", 32'(err_valid), 32'h0);
      check("rr_cnt", {cnt_0, cnt_1, cnt_2}, 32'h0);
      check("rr_multi", 32'(multi_fault), 32'h0);
      check("rr_port_out", 32'(port_out), 32'h0);
      err_ready = 1'b1;
      lanes(4'b1010, 4'b1010, 4'b1010);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rr_clean_valid", 32'(err_valid), 32'h0);
         check("rr_clean_scrub", 32'(scrub_en), 32'h0);
      end
      check("rr_port_out_new", 32'(port_out), 32'hA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
